// File: rtl/writeback_queue.sv
// Writeback queue: buffers MEM-stage results and issues them in order to the register file write port.
// Optional feature: define WB_BYPASS_EN to let a result skip the empty queue straight into the output registers.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          resultValidM,
    input  logic [4:0]    resultIndexM,
    input  logic [31:0]   resultDataM,
    output logic          resultReadyM,
    input  logic          drainEnable,
    output logic          regWriteW,
    output logic [4:0]    indexWB,
    output logic [31:0]   valueInput,
    input  logic [4:0]    fwdIndex1,
    input  logic [4:0]    fwdIndex2,
    output logic          fwdHit1,
    output logic          fwdHit2,
    output logic [31:0]   fwdValue1,
    output logic [31:0]   fwdValue2,
    output logic [AW:0]   count
);

    logic [AW:0]   wrPtr_r;
    logic [AW:0]   rdPtr_r;
    logic [4:0]    idxMem_r  [DEPTH];
    logic [31:0]   dataMem_r [DEPTH];

    logic          empty_s;
    logic          full_s;
    logic          accept_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic [AW:0]   count_s;
    logic [AW-1:0] slot_s;

    assign empty_s = (wrPtr_r == rdPtr_r);
    // The wrap bit is what separates full from empty when the low bits coincide.
    assign full_s  = (wrPtr_r[AW-1:0] == rdPtr_r[AW-1:0]) && (wrPtr_r[AW] != rdPtr_r[AW]);
    assign count_s = wrPtr_r - rdPtr_r;

    assign resultReadyM = !full_s;
    assign count        = count_s;

    // Handshake decode: index-0 results complete the handshake but are dropped.
    always_comb begin
        accept_s = resultValidM && !full_s && (resultIndexM != 5'd0);
`ifdef WB_BYPASS_EN
        bypass_s = accept_s && empty_s && drainEnable;
`else
        bypass_s = 1'b0;
`endif
        push_s   = accept_s && !bypass_s;
        pop_s    = drainEnable && !empty_s;
    end

    // Queue storage and pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_r <= {(AW+1){1'b0}};
            rdPtr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                idxMem_r[i]  <= 5'd0;
                dataMem_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                idxMem_r[wrPtr_r[AW-1:0]]  <= resultIndexM;
                dataMem_r[wrPtr_r[AW-1:0]] <= resultDataM;
                wrPtr_r <= wrPtr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Register-file write port registers; index and data hold between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWriteW  <= 1'b0;
            indexWB    <= 5'd0;
            valueInput <= 32'd0;
        end else begin
            regWriteW <= pop_s || bypass_s;
            if (pop_s) begin
                indexWB    <= idxMem_r[rdPtr_r[AW-1:0]];
                valueInput <= dataMem_r[rdPtr_r[AW-1:0]];
            end else if (bypass_s) begin
                indexWB    <= resultIndexM;
                valueInput <= resultDataM;
            end
        end
    end

    // Forwarding scan from oldest to youngest so the youngest match overrides.
    always_comb begin
        fwdHit1   = 1'b0;
        fwdValue1 = 32'd0;
        fwdHit2   = 1'b0;
        fwdValue2 = 32'd0;
        slot_s    = rdPtr_r[AW-1:0];
        for (int k = 0; k < DEPTH; k++) begin
            slot_s = rdPtr_r[AW-1:0] + AW'(k);
            if (((AW+1)'(k) < count_s) && (fwdIndex1 != 5'd0) && (idxMem_r[slot_s] == fwdIndex1)) begin
                fwdHit1   = 1'b1;
                fwdValue1 = dataMem_r[slot_s];
            end else begin
                fwdHit1   = fwdHit1;
                fwdValue1 = fwdValue1;
            end
            if (((AW+1)'(k) < count_s) && (fwdIndex2 != 5'd0) && (idxMem_r[slot_s] == fwdIndex2)) begin
                fwdHit2   = 1'b1;
                fwdValue2 = dataMem_r[slot_s];
            end else begin
                fwdHit2   = fwdHit2;
                fwdValue2 = fwdValue2;
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus queues expected writes, a negedge monitor checks them.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        resultValidM = 1'b0;
    logic [4:0]  resultIndexM = 5'd0;
    logic [31:0] resultDataM = 32'd0;
    logic        resultReadyM;
    logic        drainEnable = 1'b0;
    logic        regWriteW;
    logic [4:0]  indexWB;
    logic [31:0] valueInput;
    logic [4:0]  fwdIndex1 = 5'd0;
    logic [4:0]  fwdIndex2 = 5'd0;
    logic        fwdHit1, fwdHit2;
    logic [31:0] fwdValue1, fwdValue2;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    logic [36:0] sb[$];

    writeback_queue #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .resultValidM(resultValidM), .resultIndexM(resultIndexM), .resultDataM(resultDataM),
        .resultReadyM(resultReadyM), .drainEnable(drainEnable),
        .regWriteW(regWriteW), .indexWB(indexWB), .valueInput(valueInput),
        .fwdIndex1(fwdIndex1), .fwdIndex2(fwdIndex2),
        .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
        .fwdValue1(fwdValue1), .fwdValue2(fwdValue2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] idx, input logic [31:0] data);
        resultValidM = 1'b1;
        resultIndexM = idx;
        resultDataM  = data;
        if (idx != 5'd0) sb.push_back({idx, data});
        tick(1);
        resultValidM = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (reset && regWriteW) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {27'd0, indexWB, valueInput}, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("write_entry", {27'd0, indexWB, valueInput}, {27'd0, e});
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_regWriteW", 64'(regWriteW), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(resultReadyM), 64'd1);
        check("rst_index_value", {27'd0, indexWB, valueInput}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(1);

        // Latency of a single result into an empty queue.
        drainEnable = 1'b1;
        push(5'd5, 32'h0000_00AA);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("lat_edge1", 64'(regWriteW), 64'd1);
        @(negedge clk);
        check("lat_edge2", 64'(regWriteW), 64'd0);
`else
        check("lat_edge1", 64'(regWriteW), 64'd0);
        @(negedge clk);
        check("lat_edge2", 64'(regWriteW), 64'd1);
        @(negedge clk);
        check("lat_edge3", 64'(regWriteW), 64'd0);
`endif
        tick(2);

        // Fill with drain stalled, then a rejected fifth result.
        drainEnable = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(resultReadyM), 64'd0);
        resultValidM = 1'b1;
        resultIndexM = 5'd9;
        resultDataM  = 32'h999;
        tick(1);
        resultValidM = 1'b0;
        check("full_reject_count", 64'(count), 64'd4);
        drainEnable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("drain_consecutive", 64'(regWriteW), 64'd1);
        end
        tick(1);
        check("drain_count", 64'(count), 64'd0);

        // Forwarding picks the youngest of two entries to the same register.
        drainEnable = 1'b0;
        fwdIndex1 = 5'd7;
        fwdIndex2 = 5'd3;
        push(5'd7, 32'h11);
        check("fwd_first_value", 64'(fwdValue1), 64'h11);
        push(5'd7, 32'h22);
        check("fwd_hit1", 64'(fwdHit1), 64'd1);
        check("fwd_youngest", 64'(fwdValue1), 64'h22);
        check("fwd_miss_hit2", 64'(fwdHit2), 64'd0);
        check("fwd_miss_value2", 64'(fwdValue2), 64'd0);
        drainEnable = 1'b1;
        tick(3);
        check("fwd_after_drain", 64'(fwdHit1), 64'd0);

        // Index 0 completes the handshake but enqueues nothing.
        fwdIndex1 = 5'd0;
        resultValidM = 1'b1;
        resultIndexM = 5'd0;
        resultDataM  = 32'hFFFF_FFFF;
        check("zero_ready", 64'(resultReadyM), 64'd1);
        tick(1);
        resultValidM = 1'b0;
        check("zero_count", 64'(count), 64'd0);
        check("zero_fwd", 64'(fwdHit1), 64'd0);
        tick(2);

        // Steady push+pop across pointer wrap.
        drainEnable = 1'b0;
        for (int i = 0; i < 3; i++) push(5'(10 + i), 32'h200 + 32'(i));
        drainEnable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(5'(13 + i), 32'h300 + 32'(i));
            check("steady_count", 64'(count), 64'd3);
        end
        tick(5);
        check("steady_drained", 64'(count), 64'd0);

        // Asynchronous reset with entries queued and a write in flight.
        drainEnable = 1'b0;
        push(5'd20, 32'h2020);
        push(5'd21, 32'h2121);
        push(5'd22, 32'h2222);
        fwdIndex1 = 5'd21;
        drainEnable = 1'b1;
        @(posedge clk);
        #1;
        drainEnable = 1'b0;
        @(negedge clk);
        check("pre_rst_write", 64'(regWriteW), 64'd1);
        check("pre_rst_count", 64'(count), 64'd2);
        check("pre_rst_fwd", 64'(fwdHit1), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async_regWriteW", 64'(regWriteW), 64'd0);
        check("async_index_value", {27'd0, indexWB, valueInput}, 64'd0);
        check("async_count", 64'(count), 64'd0);
        check("async_ready", 64'(resultReadyM), 64'd1);
        check("async_fwd", {31'd0, fwdHit1, fwdValue1}, 64'd0);
        sb.delete();
        drainEnable = 1'b1;
        #20;
        @(negedge clk);
        reset = 1'b1;
        tick(4);
        check("post_rst_count", 64'(count), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
